// File: rtl/mpt_plb_cache.sv
// Fully-associative permission lookaside buffer caching MPT walk results
// as (SDID, page tag, page size, permission), with scoped flush and perf counters.
module mpt_plb_cache #(
   parameter int NUM_ENTRIES = 8,
   parameter int PLEN        = 56,
   parameter int SDID_LEN    = 6,
   parameter int SHIFT_4K    = 12,
   parameter int SHIFT_MID   = 21,
   parameter int SHIFT_1G    = 30,
   parameter int CNT_W       = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                lkp_valid_i,
   output logic                lkp_ready_o,
   input  logic [SDID_LEN-1:0] lkp_sdid_i,
   input  logic [PLEN-1:0]     lkp_spa_i,
   output logic                rsp_valid_o,
   output logic                rsp_hit_o,
   output logic [1:0]          rsp_perm_o,
   input  logic                fill_valid_i,
   input  logic [SDID_LEN-1:0] fill_sdid_i,
   input  logic [PLEN-1:0]     fill_spa_i,
   input  logic [1:0]          fill_size_i,
   input  logic [1:0]          fill_perm_i,
   input  logic                flush_req_i,
   input  logic [1:0]          flush_scope_i,
   input  logic [SDID_LEN-1:0] flush_sdid_i,
   input  logic [PLEN-1:0]     flush_spa_i,
   output logic                flush_done_o,
   output logic [CNT_W-1:0]    hit_cnt_o,
   output logic [CNT_W-1:0]    miss_cnt_o
);

   localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FLUSH,
      S_DONE
   } state_e;

   state_e state_q, state_d;

   // Entry storage; tags are held with the in-page offset bits already cleared
   logic [NUM_ENTRIES-1:0] valid_q;
   logic [SDID_LEN-1:0]    sdid_q [NUM_ENTRIES];
   logic [PLEN-1:0]        tag_q  [NUM_ENTRIES];
   logic [1:0]             size_q [NUM_ENTRIES];
   logic [1:0]             perm_q [NUM_ENTRIES];
   logic [IDX_W-1:0]       rr_q;

   logic [1:0]             flush_scope_q;
   logic [SDID_LEN-1:0]    flush_sdid_q;
   logic [PLEN-1:0]        flush_spa_q;

   logic                   lkp_acc;
   logic                   lkp_hit;
   logic [1:0]             lkp_perm;

   logic [PLEN-1:0]        fill_tag;
   logic                   fill_acc;
   logic                   same_found;
   logic [IDX_W-1:0]       same_idx;
   logic                   free_found;
   logic [IDX_W-1:0]       free_idx;
   logic [IDX_W-1:0]       fill_idx;

   logic [NUM_ENTRIES-1:0] kill;
   logic                   flush_start;

   // Address mask keeping only the tag bits for a given page size
   function automatic logic [PLEN-1:0] page_mask(input logic [1:0] size);
      logic [PLEN-1:0] ones;
      ones = '1;
      case (size)
         2'd0:    page_mask = ones << SHIFT_4K;
         2'd1:    page_mask = ones << SHIFT_MID;
         default: page_mask = ones << SHIFT_1G;
      endcase
   endfunction

   // State register for the flush sequencer
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state and handshake outputs; lookups are only taken while idle
   always_comb begin
      state_d      = state_q;
      lkp_ready_o  = 1'b0;
      flush_done_o = 1'b0;
      case (state_q)
         S_IDLE: begin
            lkp_ready_o = 1'b1;
            if (flush_req_i) state_d = S_FLUSH;
         end
         S_FLUSH: state_d = S_DONE;
         S_DONE: begin
            flush_done_o = 1'b1;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign flush_start = (state_q == S_IDLE) && flush_req_i;
   assign lkp_acc     = lkp_valid_i && lkp_ready_o;

   // Lookup match against current contents; scanning downwards lets the lowest index win
   always_comb begin
      lkp_hit  = 1'b0;
      lkp_perm = 2'b00;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (valid_q[i] && (sdid_q[i] == lkp_sdid_i) &&
             ((lkp_spa_i & page_mask(size_q[i])) == tag_q[i])) begin
            lkp_hit  = 1'b1;
            lkp_perm = perm_q[i];
         end
      end
   end

   // Fill slot choice: identical entry first, then lowest free slot, else round-robin victim
   always_comb begin
      fill_tag   = fill_spa_i & page_mask(fill_size_i);
      same_found = 1'b0;
      same_idx   = '0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (valid_q[i] && (sdid_q[i] == fill_sdid_i) && (size_q[i] == fill_size_i) &&
             (tag_q[i] == fill_tag)) begin
            same_found = 1'b1;
            same_idx   = IDX_W'(i);
         end
         if (!valid_q[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
      if (same_found)      fill_idx = same_idx;
      else if (free_found) fill_idx = free_idx;
      else                 fill_idx = rr_q;
   end

   assign fill_acc = fill_valid_i && (fill_size_i != 2'd3) && (state_q == S_IDLE) && !flush_req_i;

   // Entries selected for invalidation by the latched flush scope
   always_comb begin
      kill = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         case (flush_scope_q)
            2'd1: kill[i] = valid_q[i] && (sdid_q[i] == flush_sdid_q);
            2'd2: kill[i] = valid_q[i] && (sdid_q[i] == flush_sdid_q) &&
                            ((flush_spa_q & page_mask(size_q[i])) == tag_q[i]);
            default: kill[i] = valid_q[i];
         endcase
      end
   end

   // Capture flush parameters when the request is taken so they stay stable through FLUSH
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         flush_scope_q <= 2'd0;
         flush_sdid_q  <= '0;
         flush_spa_q   <= '0;
      end else if (flush_start) begin
         flush_scope_q <= flush_scope_i;
         flush_sdid_q  <= flush_sdid_i;
         flush_spa_q   <= flush_spa_i;
      end
   end

   // Entry array and replacement pointer: flush invalidation or walker fill
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= '0;
         rr_q    <= '0;
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            sdid_q[i] <= '0;
            tag_q[i]  <= '0;
            size_q[i] <= 2'd0;
            perm_q[i] <= 2'd0;
         end
      end else if (state_q == S_FLUSH) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (kill[i]) valid_q[i] <= 1'b0;
         end
         if ((flush_scope_q == 2'd0) || (flush_scope_q == 2'd3)) rr_q <= '0;
      end else if (fill_acc) begin
         valid_q[fill_idx] <= 1'b1;
         sdid_q[fill_idx]  <= fill_sdid_i;
         tag_q[fill_idx]   <= fill_tag;
         size_q[fill_idx]  <= fill_size_i;
         perm_q[fill_idx]  <= fill_perm_i;
         if (!same_found && !free_found) rr_q <= rr_q + IDX_W'(1);
      end
   end

   // Registered lookup response and saturating hit/miss counters
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rsp_valid_o <= 1'b0;
         rsp_hit_o   <= 1'b0;
         rsp_perm_o  <= 2'b00;
         hit_cnt_o   <= '0;
         miss_cnt_o  <= '0;
      end else begin
         rsp_valid_o <= lkp_acc;
         rsp_hit_o   <= lkp_acc && lkp_hit;
         rsp_perm_o  <= lkp_acc ? lkp_perm : 2'b00;
         if (lkp_acc && lkp_hit && (hit_cnt_o != '1))   hit_cnt_o  <= hit_cnt_o + CNT_W'(1);
         if (lkp_acc && !lkp_hit && (miss_cnt_o != '1)) miss_cnt_o <= miss_cnt_o + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_mpt_plb_cache.sv
// Self-checking bench for mpt_plb_cache: scenario tasks push expected responses
// to a scoreboard queue, a negedge monitor pops and compares them.
module tb_mpt_plb_cache;

   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic        clk;
   logic        rst;
   logic        lkp_valid;
   logic        lkp_ready;
   logic [5:0]  lkp_sdid;
   logic [55:0] lkp_spa;
   logic        rsp_valid;
   logic        rsp_hit;
   logic [1:0]  rsp_perm;
   logic        fill_valid;
   logic [5:0]  fill_sdid;
   logic [55:0] fill_spa;
   logic [1:0]  fill_size;
   logic [1:0]  fill_perm;
   logic        flush_req;
   logic [1:0]  flush_scope;
   logic [5:0]  flush_sdid;
   logic [55:0] flush_spa;
   logic        flush_done;
   logic [CNT_W-1:0] hit_cnt;
   logic [CNT_W-1:0] miss_cnt;

   typedef struct {
      logic       hit;
      logic [1:0] perm;
      int         hc;
      int         mc;
      int         due;
   } exp_t;

   exp_t sb[$];
   int   n_cmp;
   int   n_fail;
   int   cyc;
   int   exp_hc;
   int   exp_mc;

   mpt_plb_cache #(
      .NUM_ENTRIES(8), .PLEN(56), .SDID_LEN(6), .SHIFT_4K(12),
      .SHIFT_MID(21), .SHIFT_1G(30), .CNT_W(CNT_W)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .lkp_valid_i(lkp_valid), .lkp_ready_o(lkp_ready), .lkp_sdid_i(lkp_sdid), .lkp_spa_i(lkp_spa),
      .rsp_valid_o(rsp_valid), .rsp_hit_o(rsp_hit), .rsp_perm_o(rsp_perm),
      .fill_valid_i(fill_valid), .fill_sdid_i(fill_sdid), .fill_spa_i(fill_spa),
      .fill_size_i(fill_size), .fill_perm_i(fill_perm),
      .flush_req_i(flush_req), .flush_scope_i(flush_scope), .flush_sdid_i(flush_sdid),
      .flush_spa_i(flush_spa), .flush_done_o(flush_done),
      .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter used to time-stamp scoreboard entries
   initial cyc = 0;
   always @(posedge clk) cyc++;

   // Scoreboard monitor: compares each response against the oldest expectation
   always @(negedge clk) begin
      if (!rst) begin
         if (rsp_valid) begin
            if (sb.size() == 0) begin
               n_cmp++; n_fail++;
               $display("[TB] FAIL rsp_unexpected: got rsp_valid=1 required no response (cycle %0d)", cyc);
            end else begin
               exp_t e;
               e = sb.pop_front();
               n_cmp++;
               if (e.due != cyc) begin
                  n_fail++;
                  $display("[TB] FAIL rsp_latency: got response at cycle %0d required %0d", cyc, e.due);
               end
               n_cmp++;
               if (rsp_hit !== e.hit) begin
                  n_fail++;
                  $display("[TB] FAIL rsp_hit: got %0b required %0b", rsp_hit, e.hit);
               end
               n_cmp++;
               if (rsp_perm !== e.perm) begin
                  n_fail++;
                  $display("[TB] FAIL rsp_perm: got %0d required %0d", rsp_perm, e.perm);
               end
               n_cmp++;
               if (hit_cnt !== CNT_W'(e.hc)) begin
                  n_fail++;
                  $display("[TB] FAIL hit_cnt: got %0d required %0d", hit_cnt, e.hc);
               end
               n_cmp++;
               if (miss_cnt !== CNT_W'(e.mc)) begin
                  n_fail++;
                  $display("[TB] FAIL miss_cnt: got %0d required %0d", miss_cnt, e.mc);
               end
            end
         end else begin
            n_cmp++;
            if ((rsp_hit !== 1'b0) || (rsp_perm !== 2'b00)) begin
               n_fail++;
               $display("[TB] FAIL rsp_idle: got hit=%0b perm=%0d required hit=0 perm=0", rsp_hit, rsp_perm);
            end
            if ((sb.size() != 0) && (sb[0].due <= cyc)) begin
               n_cmp++; n_fail++;
               $display("[TB] FAIL rsp_missing: got no response required one due at cycle %0d", sb[0].due);
               void'(sb.pop_front());
            end
         end
      end
   end

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a lookup for the coming edge and record its expected response
   task automatic lookup_push(input logic [5:0] sdid, input logic [55:0] spa,
                              input logic eh, input logic [1:0] ep);
      exp_t e;
      lkp_valid = 1'b1;
      lkp_sdid  = sdid;
      lkp_spa   = spa;
      if (eh) exp_hc = (exp_hc >= CNT_MAX) ? CNT_MAX : exp_hc + 1;
      else    exp_mc = (exp_mc >= CNT_MAX) ? CNT_MAX : exp_mc + 1;
      e.hit  = eh;
      e.perm = ep;
      e.hc   = exp_hc;
      e.mc   = exp_mc;
      e.due  = cyc + 1;
      sb.push_back(e);
   endtask

   // Single isolated lookup
   task automatic lookup_once(input logic [5:0] sdid, input logic [55:0] spa,
                              input logic eh, input logic [1:0] ep);
      lookup_push(sdid, spa, eh, ep);
      tick();
      lkp_valid = 1'b0;
   endtask

   // Single walker fill
   task automatic fill_once(input logic [5:0] sdid, input logic [55:0] spa,
                            input logic [1:0] size, input logic [1:0] perm);
      fill_valid = 1'b1;
      fill_sdid  = sdid;
      fill_spa   = spa;
      fill_size  = size;
      fill_perm  = perm;
      tick();
      fill_valid = 1'b0;
   endtask

   // Reset the DUT and the bench model; checks the values seen while in reset
   task automatic test_reset();
      rst = 1'b1;
      lkp_valid = 1'b0; fill_valid = 1'b0; flush_req = 1'b0;
      sb.delete();
      exp_hc = 0;
      exp_mc = 0;
      tick();
      tick();
      n_cmp++;
      if ((lkp_ready !== 1'b1) || (rsp_valid !== 1'b0) || (flush_done !== 1'b0)) begin
         n_fail++;
         $display("[TB] FAIL reset_ctrl: got ready=%0b rsp_valid=%0b done=%0b required 1/0/0",
                  lkp_ready, rsp_valid, flush_done);
      end
      n_cmp++;
      if ((hit_cnt !== '0) || (miss_cnt !== '0) || (rsp_hit !== 1'b0) || (rsp_perm !== 2'b00)) begin
         n_fail++;
         $display("[TB] FAIL reset_cnt: got hit_cnt=%0d miss_cnt=%0d hit=%0b perm=%0d required all 0",
                  hit_cnt, miss_cnt, rsp_hit, rsp_perm);
      end
      rst = 1'b0;
      tick();
   endtask

   // Cold miss, then a 1G entry matched anywhere in its page and only for its own domain
   task automatic test_basic_lookup();
      lookup_once(6'd1, 56'h1000, 1'b0, 2'b00);
      fill_once(6'd1, 56'h4000_0123, 2'd2, 2'b11);
      lookup_once(6'd1, 56'h7FFF_F000, 1'b1, 2'b11);
      lookup_once(6'd2, 56'h7FFF_F000, 1'b0, 2'b00);
      lookup_once(6'd1, 56'h8000_0000, 1'b0, 2'b00);
      tick(); tick();
   endtask

   // Nine 4K fills into eight slots: the ninth evicts slot 0, the tenth slot 1
   task automatic test_eviction();
      test_reset();
      for (int i = 0; i < 9; i++) fill_once(6'd3, 56'(i) << 12, 2'd0, 2'(i));
      lookup_once(6'd3, 56'h0000, 1'b0, 2'b00);
      lookup_once(6'd3, 56'h8000, 1'b1, 2'd0);
      lookup_once(6'd3, 56'h1000, 1'b1, 2'd1);
      fill_once(6'd3, 56'h9000, 2'd0, 2'd1);
      lookup_once(6'd3, 56'h1000, 1'b0, 2'b00);
      lookup_once(6'd3, 56'h2000, 1'b1, 2'd2);
      lookup_once(6'd3, 56'h9ABC, 1'b1, 2'd1);
      tick(); tick();
   endtask

   // Refill of an identical page updates the permission in place
   task automatic test_refill();
      test_reset();
      fill_once(6'd1, 56'h5000, 2'd0, 2'b10);
      fill_once(6'd1, 56'h6000, 2'd0, 2'b11);
      fill_once(6'd1, 56'h5000, 2'd0, 2'b01);
      lookup_once(6'd1, 56'h5FFF, 1'b1, 2'b01);
      lookup_once(6'd1, 56'h6000, 1'b1, 2'b11);
      tick(); tick();
   endtask

   // Scoped flushes: handshake timing, pre-flush answer in the sample cycle, selective kill
   task automatic test_flush_scope();
      test_reset();
      fill_once(6'd1, 56'h4000_0123, 2'd2, 2'b11);
      fill_once(6'd1, 56'h5000, 2'd0, 2'b10);
      fill_once(6'd2, 56'h4000_0000, 2'd2, 2'b01);
      flush_req   = 1'b1;
      flush_scope = 2'd2;
      flush_sdid  = 6'd1;
      flush_spa   = 56'h4020_0000;
      lookup_push(6'd1, 56'h7000_0000, 1'b1, 2'b11);
      tick();
      flush_req = 1'b0;
      lkp_valid = 1'b0;
      n_cmp++;
      if ((lkp_ready !== 1'b0) || (flush_done !== 1'b0)) begin
         n_fail++;
         $display("[TB] FAIL flush_cyc1: got ready=%0b done=%0b required 0/0", lkp_ready, flush_done);
      end
      tick();
      n_cmp++;
      if ((lkp_ready !== 1'b0) || (flush_done !== 1'b1)) begin
         n_fail++;
         $display("[TB] FAIL flush_cyc2: got ready=%0b done=%0b required 0/1", lkp_ready, flush_done);
      end
      tick();
      n_cmp++;
      if ((lkp_ready !== 1'b1) || (flush_done !== 1'b0)) begin
         n_fail++;
         $display("[TB] FAIL flush_cyc3: got ready=%0b done=%0b required 1/0", lkp_ready, flush_done);
      end
      lookup_once(6'd1, 56'h7000_0000, 1'b0, 2'b00);
      lookup_once(6'd1, 56'h5000, 1'b1, 2'b10);
      lookup_once(6'd2, 56'h4000_0000, 1'b1, 2'b01);
      flush_req   = 1'b1;
      flush_scope = 2'd1;
      flush_sdid  = 6'd2;
      tick();
      flush_req = 1'b0;
      tick(); tick();
      lookup_once(6'd2, 56'h4000_0000, 1'b0, 2'b00);
      lookup_once(6'd1, 56'h5000, 1'b1, 2'b10);
      tick(); tick();
   endtask

   // Fills in the flush-sample, FLUSH and DONE cycles are all dropped; scope 0 clears everything
   task automatic test_fill_during_flush();
      fill_valid = 1'b1; fill_sdid = 6'd1; fill_spa = 56'h9000; fill_size = 2'd0; fill_perm = 2'b11;
      flush_req = 1'b1; flush_scope = 2'd0;
      tick();
      flush_req = 1'b0;
      fill_spa  = 56'hA000;
      tick();
      fill_spa  = 56'hB000;
      tick();
      fill_valid = 1'b0;
      lookup_once(6'd1, 56'h9000, 1'b0, 2'b00);
      lookup_once(6'd1, 56'hA000, 1'b0, 2'b00);
      lookup_once(6'd1, 56'hB000, 1'b0, 2'b00);
      lookup_once(6'd1, 56'h5000, 1'b0, 2'b00);
      tick(); tick();
   endtask

   // Same-cycle fill is invisible to a concurrent lookup; reserved size is ignored
   task automatic test_fill_visibility();
      fill_valid = 1'b1; fill_sdid = 6'd5; fill_spa = 56'hC000; fill_size = 2'd0; fill_perm = 2'b10;
      lookup_push(6'd5, 56'hC000, 1'b0, 2'b00);
      tick();
      fill_valid = 1'b0;
      lookup_once(6'd5, 56'hC123, 1'b1, 2'b10);
      fill_once(6'd5, 56'hD000, 2'd3, 2'b11);
      lookup_once(6'd5, 56'hD000, 1'b0, 2'b00);
      tick(); tick();
   endtask

   // Reset during FLUSH: straight back to IDLE, no done pulse, contents gone
   task automatic test_reset_mid_flush();
      fill_once(6'd7, 56'hE000, 2'd0, 2'b01);
      flush_req = 1'b1; flush_scope = 2'd1; flush_sdid = 6'd9;
      tick();
      flush_req = 1'b0;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ((lkp_ready !== 1'b1) || (flush_done !== 1'b0)) begin
         n_fail++;
         $display("[TB] FAIL rst_mid_flush: got ready=%0b done=%0b required 1/0", lkp_ready, flush_done);
      end
      sb.delete();
      exp_hc = 0;
      exp_mc = 0;
      tick();
      rst = 1'b0;
      tick();
      n_cmp++;
      if (flush_done !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL rst_no_done: got done=%0b required 0", flush_done);
      end
      lookup_once(6'd7, 56'hE000, 1'b0, 2'b00);
      tick(); tick();
   endtask

   // Back-to-back hits drive the hit counter into saturation
   task automatic test_back_to_back();
      fill_once(6'd4, 56'h1000, 2'd0, 2'b11);
      for (int i = 0; i < CNT_MAX + 3; i++) begin
         lookup_push(6'd4, 56'h1000 + 56'(i), 1'b1, 2'b11);
         tick();
      end
      lkp_valid = 1'b0;
      tick(); tick();
      n_cmp++;
      if (hit_cnt !== CNT_W'(CNT_MAX)) begin
         n_fail++;
         $display("[TB] FAIL hit_sat: got %0d required %0d", hit_cnt, CNT_MAX);
      end
   endtask

   // Hard time limit so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL timeout: got no finish required finish before time limit");
      $fatal(1, "[TB] time limit reached");
   end

   // Test sequence
   initial begin
      n_cmp = 0; n_fail = 0;
      exp_hc = 0; exp_mc = 0;
      rst = 1'b1;
      lkp_valid = 1'b0; lkp_sdid = '0; lkp_spa = '0;
      fill_valid = 1'b0; fill_sdid = '0; fill_spa = '0; fill_size = '0; fill_perm = '0;
      flush_req = 1'b0; flush_scope = '0; flush_sdid = '0; flush_spa = '0;
      test_reset();
      test_basic_lookup();
      test_eviction();
      test_refill();
      test_flush_scope();
      test_fill_during_flush();
      test_fill_visibility();
      test_reset_mid_flush();
      test_back_to_back();
      tick(); tick();
      n_cmp++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL sb_drain: got %0d pending responses required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
